// File: rtl/sram_controller_if.sv
// CPU-side request bus and SRAM pin bundle for sram_controller.
// The controller attaches to the slave modport. The CPU/SRAM side
// attaches to the master modport.
interface sram_controller_if;
    // CPU side
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        ready;
    // SRAM side
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;

    modport slave (
        input  wr_en, rd_en, address, writeData, sram_dq_in,
        output readData, ready, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
    );

    modport master (
        output wr_en, rd_en, address, writeData, sram_dq_in,
        input  readData, ready, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
    );
endinterface

// File: rtl/sram_controller.sv
// Bridges a 32-bit MEM-stage load/store to a 16-bit asynchronous SRAM.
// Each access takes two half-word cycles (low half, then high half) and
// WAIT_CYCLES settle cycles. The pipeline is frozen through `ready`
// until the transaction finishes.
module sram_controller #(
    parameter int unsigned WAIT_CYCLES = 3,            // 1..15
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        ACC_LO,
        ACC_HI,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  wait_cnt_q;
    logic        op_write_q;
    logic [16:0] word_q;
    logic [31:0] data_q;
    logic [31:0] read_data_q;
    logic [17:0] sram_addr_q;
    logic        sram_we_n_q;
    logic        sram_dq_oe_q;
    logic [15:0] sram_dq_out_q;

    logic        req;
    logic [16:0] word_d;

    assign req    = bus.wr_en | bus.rd_en;
    // The word index wraps modulo 2^17. Addresses below BASE_ADDR
    // therefore land at the top of the SRAM.
    assign word_d = 17'((bus.address - BASE_ADDR) >> 2);

    // Sequencer: state, latched request, and registered SRAM strobes.
    // NOTE: the SRAM pins are registered. Each is loaded on the edge that
    // enters the state where it must be valid, so the pins carry no glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wait_cnt_q    <= 4'd0;
            op_write_q    <= 1'b0;
            word_q        <= 17'd0;
            data_q        <= 32'd0;
            read_data_q   <= 32'd0;
            sram_addr_q   <= 18'd0;
            sram_we_n_q   <= 1'b1;
            sram_dq_oe_q  <= 1'b0;
            sram_dq_out_q <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q       <= ACC_LO;
                        op_write_q    <= bus.wr_en;     // write wins over read
                        word_q        <= word_d;
                        data_q        <= bus.writeData;
                        sram_addr_q   <= {word_d, 1'b0};
                        sram_we_n_q   <= ~bus.wr_en;
                        sram_dq_oe_q  <= bus.wr_en;
                        sram_dq_out_q <= bus.wr_en ? bus.writeData[15:0] : 16'd0;
                    end
                end
                ACC_LO: begin
                    state_q       <= ACC_HI;
                    if (!op_write_q) begin
                        read_data_q[15:0] <= bus.sram_dq_in;
                    end
                    sram_addr_q   <= {word_q, 1'b1};
                    sram_dq_out_q <= op_write_q ? data_q[31:16] : 16'd0;
                end
                ACC_HI: begin
                    state_q       <= WAIT;
                    wait_cnt_q    <= WAIT_LOAD;
                    if (!op_write_q) begin
                        read_data_q[31:16] <= bus.sram_dq_in;
                    end
                    sram_addr_q   <= 18'd0;
                    sram_we_n_q   <= 1'b1;
                    sram_dq_oe_q  <= 1'b0;
                    sram_dq_out_q <= 16'd0;
                end
                WAIT: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_q <= DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Freeze starts combinationally in the request cycle itself.
    assign bus.ready       = (state_q == DONE) || ((state_q == IDLE) && !req);

    assign bus.readData    = read_data_q;
    assign bus.sram_addr   = sram_addr_q;
    assign bus.sram_we_n   = sram_we_n_q;
    assign bus.sram_dq_oe  = sram_dq_oe_q;
    assign bus.sram_dq_out = sram_dq_out_q;

endmodule
